sme_mask: RTL
=============

Name: sme_mask

Overview:
- Share-serial masking unit in the SME datapath. It sits directly upstream of the SME crypto/AES unit and produces the share arrays that unit consumes.
- Operations:
  - mask: split a plain word into n boolean shares.
  - remask: refresh existing shares with fresh randomness.
  - unmask: recombine shares into share 0.
- Processes one share per cycle, so only one random word is needed per step. Uses the same valid/ready and flush conventions as the rest of SME.

Parameters:
- XLEN, 32: datapath/share width in bits.
- SMAX, 3: maximum number of hardware shares (3 or more). Share arrays are SMAX entries of XLEN bits.

Ports:
- g_clk  in  1  global clock
- g_resetn  in  1  reset
- smectl_d  in  4  requested share count
- rng  in  SMAX x XLEN  per-share random words; rng[0] unused
- flush  in  1  abort current operation, discard result
- valid  in  1  request valid; held with ops/operands until ready
- ready  out  1  result on rd valid this cycle; transfer = valid && ready
- op_mask  in  1  mask operation
- op_remask  in  1  remask operation
- op_unmask  in  1  unmask operation
- rs1  in  SMAX x XLEN  input shares; for mask only rs1[0] (plain value) is used
- rd  out  SMAX x XLEN  output shares

Behaviour:
- Reset: g_resetn, synchronous, active-low; clock g_clk. On reset: state=IDLE, ctr=0, all share registers s[i]=0. Hence ready=0 and rd all zero.
- Effective share count n = min(max(smectl_d,2),SMAX). It is sampled only on accept and held in a register for the whole operation.
- Op select: unmask > remask > mask if more than one op bit is set. With valid=1 and no op bit set, stay in IDLE, ready=0.
- States: IDLE, RUN, DONE. ready = valid && state==DONE.
- IDLE, valid with an op set (accept):
  - latch op and n; ctr<=1; go to RUN.
  - mask: s[0]<=rs1[0], s[i>0]<=0.
  - remask/unmask: s[i]<=rs1[i] for i<n, s[i>=n]<=0.
- RUN, each cycle on share k=ctr:
  - mask: s[0]^=rng[k]; s[k]<=rng[k].
  - remask: s[0]^=rng[k]; s[k]^=rng[k].
  - unmask: s[0]^=s[k]; s[k]<=0.
  - If k==n-1, go to DONE; else ctr<=k+1.
- Latency: valid first seen in cycle T (IDLE) gives ready=1 in cycle T+n.
- DONE: hold rd stable while valid. On transfer (valid && ready), go to IDLE at the next edge. A new request can be accepted in the cycle after that.
- rd[i]=s[i] at all times. Shares i>=n are always 0.
- XOR of all output shares equals:
  - mask: rs1[0]
  - remask/unmask: XOR of input shares 0..n-1
- Flush: in any state, next state is IDLE and ctr=0. Flush has priority over accept and transfer. In the flush cycle ready still follows state.
- valid deasserted in RUN or DONE: abort, go to IDLE next cycle. No result is delivered.
- Reset mid-operation: identical to power-on reset.
- rng is sampled in every RUN cycle. The upstream RNG must present fresh words every cycle; this block does not check freshness.

Optional Feature:
- Macro: SME_MASK_ZEROISE_EN.
- Defined: on flush, abort, or completed transfer, all s[i] are cleared to 0 at the same edge as the return to IDLE. No stale share remains on rd.
- Undefined: s[i] keep their values on return to IDLE and are overwritten only at the next accept. Saves mux area.

Test Plan:
- Mask, smectl_d=3, rs1[0]=0xDEADBEEF, rng[1]=0x11111111, rng[2]=0x22222222 held constant -> ready in cycle T+3; rd={0xED9E8DDC,0x11111111,0x22222222}.
- Unmask, smectl_d=3, rs1={0xED9E8DDC,0x11111111,0x22222222} -> ready in cycle T+3; rd={0xDEADBEEF,0,0}.
- Remask, smectl_d=3, same rs1, rng[1]=rng[2]=0x0F0F0F0F -> rd={0xED9E8DDC,0x1E1E1E1E,0x2D2D2D2D}; XOR of shares = 0xDEADBEEF.
- Mask, smectl_d=2 (and separately smectl_d=0), rs1[0]=0xDEADBEEF, rng[1]=0x11111111 -> ready in cycle T+2; rd={0xCFBCAFFE,0x11111111,0}. smectl_d=9 behaves as n=3.
- Flush asserted in cycle T+1 of a mask -> IDLE next cycle; ready never asserts. A following unmask completes normally. With SME_MASK_ZEROISE_EN, rd={0,0,0} after the flush.
- Hold valid=1 across two back-to-back mask requests -> ready high exactly one cycle per request. Drop valid in cycle T+2 -> no ready pulse; state is IDLE in cycle T+3.

Source files
------------

// File: rtl/sme_mask_if.sv
// sme_mask request/result bundle: valid/ready handshake, op select,
// input shares and output shares.
interface sme_mask_if #(
  parameter int XLEN = 32,
  parameter int SMAX = 3
);
  logic                       valid;
  logic                       ready;
  logic                       op_mask;
  logic                       op_remask;
  logic                       op_unmask;
  logic [SMAX-1:0][XLEN-1:0]  rs1;
  logic [SMAX-1:0][XLEN-1:0]  rd;

  modport master (
    output valid, op_mask, op_remask, op_unmask, rs1,
    input  ready, rd
  );

  modport slave (
    input  valid, op_mask, op_remask, op_unmask, rs1,
    output ready, rd
  );
endinterface

// File: rtl/sme_mask.sv
// Share-serial mask/remask/unmask unit, one share per cycle.
// Define SME_MASK_ZEROISE_EN to clear all shares on every return to IDLE.
module sme_mask #(
  parameter int XLEN = 32,
  parameter int SMAX = 3
) (
  input  logic                      g_clk,
  input  logic                      g_resetn,
  input  logic [3:0]                smectl_d,
  input  logic [SMAX-1:0][XLEN-1:0] rng,
  input  logic                      flush,
  sme_mask_if.slave                 bus
);

  localparam int IW = $clog2(SMAX);
  localparam int CW = $clog2(SMAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_MASK,
    OP_REMASK,
    OP_UNMASK
  } op_e;

  state_e                    state_q, state_d;
  op_e                       op_q, op_d;
  logic [IW-1:0]             ctr_q, ctr_d;
  logic [CW-1:0]             n_q, n_d;
  logic [SMAX-1:0][XLEN-1:0] s_q, s_d;

  logic [CW-1:0]   n_w;
  op_e             op_w;
  logic            any_op;
  logic            last;
  logic            go_idle;
  logic [XLEN-1:0] rk;
  logic [XLEN-1:0] sk;

  always_comb begin
    if (smectl_d < 4'd2) begin
      n_w = CW'(2);
    end else if (int'(smectl_d) > SMAX) begin
      n_w = CW'(SMAX);
    end else begin
      n_w = CW'(smectl_d);
    end
  end

  // unmask > remask > mask when several op bits are set
  always_comb begin
    op_w = OP_MASK;
    if (bus.op_unmask) begin
      op_w = OP_UNMASK;
    end else if (bus.op_remask) begin
      op_w = OP_REMASK;
    end
  end

  assign any_op = bus.op_mask | bus.op_remask | bus.op_unmask;
  assign last   = (ctr_q == IW'(n_q - CW'(1)));
  assign rk     = rng[ctr_q];
  assign sk     = s_q[ctr_q];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ctr_d   = ctr_q;
    n_d     = n_q;
    s_d     = s_q;
    go_idle = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.valid && any_op) begin
          state_d = RUN;
          op_d    = op_w;
          n_d     = n_w;
          ctr_d   = IW'(1);
          s_d     = '0;
          if (op_w == OP_MASK) begin
            s_d[0] = bus.rs1[0];
          end else begin
            for (int i = 0; i < SMAX; i++) begin
              if (i < int'(n_w)) begin
                s_d[i] = bus.rs1[i];
              end
            end
          end
        end
      end
      RUN: begin
        if (!bus.valid) begin
          go_idle = 1'b1;
        end else begin
          unique case (op_q)
            OP_MASK: begin
              s_d[0]     = s_q[0] ^ rk;
              s_d[ctr_q] = rk;
            end
            OP_REMASK: begin
              s_d[0]     = s_q[0] ^ rk;
              s_d[ctr_q] = sk ^ rk;
            end
            OP_UNMASK: begin
              s_d[0]     = s_q[0] ^ sk;
              s_d[ctr_q] = '0;
            end
            default: begin
            end
          endcase
          if (last) begin
            state_d = DONE;
          end else begin
            ctr_d = ctr_q + IW'(1);
          end
        end
      end
      // ready equals valid here, so DONE always leaves after one cycle
      DONE: begin
        go_idle = 1'b1;
      end
      default: begin
        go_idle = 1'b1;
      end
    endcase

    // flush discards any accept or step taken this cycle
    if (flush) begin
      op_d    = op_q;
      n_d     = n_q;
      s_d     = s_q;
      go_idle = 1'b1;
    end

    if (go_idle) begin
      state_d = IDLE;
      ctr_d   = '0;
`ifdef SME_MASK_ZEROISE_EN
      s_d     = '0;
`else
      s_d     = s_d;
`endif
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      op_q    <= OP_MASK;
      ctr_q   <= '0;
      n_q     <= CW'(2);
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctr_q   <= ctr_d;
      n_q     <= n_d;
      s_q     <= s_d;
    end
  end

  assign bus.ready = bus.valid && (state_q == DONE);
  assign bus.rd    = s_q;

endmodule
